// File: rtl/alu_pkg.sv
// Shared types for the ALU slice: operation codes, control FSM states, and the
// default datapath width.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  // All eight 3-bit codes are defined, so no illegal-op handling is needed.
  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_DIV = 3'd3,
    OP_REM = 3'd4,
    OP_AND = 3'd5,
    OP_OR  = 3'd6,
    OP_XOR = 3'd7
  } alu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DIV  = 1'b1
  } alu_state_e;

  // DIV and REM share the iterative divider; everything else is single-cycle.
  function automatic logic is_div_op(input alu_op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/alu_if.sv
// ALU request/response channel.
// Handshake: a request is taken on a rising clock edge where valid_i==1 and
// busy_o==0; operands and operation are captured on that edge only. While
// busy_o==1, valid_i is ignored and the initiator must retry. Each accepted
// request produces exactly one single-cycle ready_o pulse; result and
// div_zero_o are valid with that pulse and hold until the next one.
interface alu_if import alu_pkg::*; #(parameter int WIDTH = ALU_WIDTH) ();

  logic             valid_i;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  alu_op_e          operation;
  logic             busy_o;
  logic             ready_o;
  logic [WIDTH-1:0] result;
  logic             div_zero_o;

  modport master (
    output valid_i, operand_a, operand_b, operation,
    input  busy_o, ready_o, result, div_zero_o
  );

  modport slave (
    input  valid_i, operand_a, operand_b, operation,
    output busy_o, ready_o, result, div_zero_o
  );

endinterface

// File: rtl/alu_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// The first step is taken on the start edge itself and the last step is
// presented combinationally on quotient_o/remainder_o while done_o is high,
// so all WIDTH steps fit between the start edge and the edge WIDTH-1 later.
module alu_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic             busy_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] rem_q, quo_q, div_q;

  logic [WIDTH-1:0] src_rem, src_quo, src_div;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_step, quo_step;

  // One restoring step; when idle the step works on the fresh operands.
  always_comb begin
    src_rem = busy_q ? rem_q : '0;
    src_quo = busy_q ? quo_q : dividend_i;
    src_div = busy_q ? div_q : divisor_i;
    trial   = {src_rem, src_quo[WIDTH-1]} - {1'b0, src_div};
    if (trial[WIDTH]) begin
      rem_step = {src_rem[WIDTH-2:0], src_quo[WIDTH-1]};
      quo_step = {src_quo[WIDTH-2:0], 1'b0};
    end else begin
      rem_step = trial[WIDTH-1:0];
      quo_step = {src_quo[WIDTH-2:0], 1'b1};
    end
  end

  // count_q holds the number of steps already registered.
  assign done_o      = busy_q && (count_q == CNT_W'(WIDTH - 1));
  assign busy_o      = busy_q;
  assign quotient_o  = quo_step;
  assign remainder_o = rem_step;

  // Iteration registers: load plus first step on start, then one step per edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      busy_q  <= 1'b0;
      count_q <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
    end else if (!busy_q) begin
      if (start_i) begin
        busy_q  <= 1'b1;
        count_q <= CNT_W'(1);
        rem_q   <= rem_step;
        quo_q   <= quo_step;
        div_q   <= divisor_i;
      end
    end else begin
      rem_q   <= rem_step;
      quo_q   <= quo_step;
      count_q <= count_q + CNT_W'(1);
      if (done_o) begin
        busy_q  <= 1'b0;
        count_q <= '0;
      end
    end
  end

endmodule

// File: rtl/alu_core.sv
// ALU responder: single-cycle fast ops, divide-by-zero early out, and an
// IDLE/DIV control FSM that parks on the iterative divider for DIV/REM.
module alu_core import alu_pkg::*; #(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic       clk_i,
  input  logic       rst_i,
  alu_if.slave       bus,
  output alu_state_e state_o
);

  alu_state_e       state_q, state_d;
  alu_op_e          op_q, op_d;
  logic             ready_q, ready_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] fast_res;

  logic             div_start, div_busy, div_done;
  logic [WIDTH-1:0] div_quo, div_rem;

  alu_divider #(.WIDTH(WIDTH)) u_div (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (div_start),
    .dividend_i  (bus.operand_a),
    .divisor_i   (bus.operand_b),
    .busy_o      (div_busy),
    .done_o      (div_done),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

  // Single-cycle operations; arithmetic wraps to WIDTH bits.
  always_comb begin
    fast_res = '0;
    case (bus.operation)
      OP_ADD:  fast_res = bus.operand_a + bus.operand_b;
      OP_SUB:  fast_res = bus.operand_a - bus.operand_b;
      OP_MUL:  fast_res = bus.operand_a * bus.operand_b;
      OP_AND:  fast_res = bus.operand_a & bus.operand_b;
      OP_OR:   fast_res = bus.operand_a | bus.operand_b;
      OP_XOR:  fast_res = bus.operand_a ^ bus.operand_b;
      default: fast_res = '0;
    endcase
  end

  // Control FSM: accept in IDLE, wait for the divider in DIV.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    ready_d   = 1'b0;
    dz_d      = dz_q;
    result_d  = result_q;
    div_start = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.valid_i) begin
          op_d = bus.operation;
          if (!is_div_op(bus.operation)) begin
            result_d = fast_res;
            dz_d     = 1'b0;
            ready_d  = 1'b1;
          end else if (bus.operand_b == '0) begin
            result_d = (bus.operation == OP_DIV) ? '1 : bus.operand_a;
            dz_d     = 1'b1;
            ready_d  = 1'b1;
          end else begin
            div_start = 1'b1;
            state_d   = ST_DIV;
          end
        end
      end
      ST_DIV: begin
        if (div_done) begin
          result_d = (op_q == OP_REM) ? div_rem : div_quo;
          dz_d     = 1'b0;
          ready_d  = 1'b1;
          state_d  = ST_IDLE;
        end else if (!div_busy) begin
          // Divider lost its job without finishing; recover to IDLE.
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_ADD;
      ready_q  <= 1'b0;
      dz_q     <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      ready_q  <= ready_d;
      dz_q     <= dz_d;
      result_q <= result_d;
    end
  end

  assign bus.busy_o     = (state_q == ST_DIV);
  assign bus.ready_o    = ready_q;
  assign bus.result     = result_q;
  assign bus.div_zero_o = dz_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_alu_core.sv
// Testbench for alu_core: directed spec scenarios plus randomized operations,
// checked against a plain-arithmetic reference model.
module tb_alu_core;
  import alu_pkg::*;

  logic       clk;
  logic       rst_i;
  alu_state_e dbg_state;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] exp_q[$];

  alu_if #(.WIDTH(32)) bus ();

  alu_core #(.WIDTH(32)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .bus     (bus),
    .state_o (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: result, divide-by-zero flag and response latency in cycles.
  function automatic void ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic dz, output int lat);
    dz  = 1'b0;
    lat = 1;
    r   = '0;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a * b;
      3'd3: if (b == 0) begin r = 32'hFFFF_FFFF; dz = 1'b1; end else begin r = a / b; lat = 32; end
      3'd4: if (b == 0) begin r = a; dz = 1'b1; end else begin r = a % b; lat = 32; end
      3'd5: r = a & b;
      3'd6: r = a | b;
      default: r = a ^ b;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver: present a request at a negedge so it is taken on the next posedge.
  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.valid_i   = 1'b1;
    bus.operation = alu_op_e'(op);
    bus.operand_a = a;
    bus.operand_b = b;
  endtask

  // One complete request: latency, result, flag, busy behaviour, single pulse, hold.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] er;
    logic        edz;
    int          elat;
    int          n;
    ref_model(op, a, b, er, edz, elat);
    drive(op, a, b);
    @(negedge clk);
    bus.valid_i   = 1'b0;
    bus.operand_a = $urandom;
    bus.operand_b = $urandom;
    n = 1;
    chk("busy_after_accept", 32'(bus.busy_o), (elat > 1) ? 32'd1 : 32'd0);
    while (!bus.ready_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(elat));
    chk("result", bus.result, er);
    chk("div_zero", 32'(bus.div_zero_o), 32'(edz));
    chk("busy_at_ready", 32'(bus.busy_o), 32'd0);
    @(negedge clk);
    chk("ready_pulse", 32'(bus.ready_o), 32'd0);
    chk("result_hold", bus.result, er);
  endtask

  initial begin
    int          pulses;
    int          first;
    logic [31:0] got;
    logic [31:0] er;
    logic        edz;
    int          elat;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [2:0]  fast_ops[6];
    logic [2:0]  b2b_op[3];
    logic [31:0] b2b_a[3], b2b_b[3], b2b_exp[3];

    fast_ops = '{3'd0, 3'd1, 3'd2, 3'd5, 3'd6, 3'd7};
    b2b_op   = '{3'd2, 3'd7, 3'd5};
    b2b_a    = '{32'd3, 32'hF0F0_F0F0, 32'h0000_FF00};
    b2b_b    = '{32'd5, 32'h0F0F_0F0F, 32'h0000_0FF0};
    b2b_exp  = '{32'd15, 32'hFFFF_FFFF, 32'h0000_0F00};

    // Reset held for three cycles
    rst_i         = 1'b0;
    bus.valid_i   = 1'b0;
    bus.operation = OP_ADD;
    bus.operand_a = '0;
    bus.operand_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.ready_o), 32'd0);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_div_zero", 32'(bus.div_zero_o), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_ready", 32'(bus.ready_o), 32'd0);
    chk("post_rst_result", bus.result, 32'd0);

    // Wrapping ADD/SUB
    run_op(3'd0, 32'hFFFF_FFFF, 32'd1);
    run_op(3'd1, 32'd0, 32'd1);

    // Back-to-back fast ops with fixed expected values
    for (int i = 0; i < 3; i++) begin
      drive(b2b_op[i], b2b_a[i], b2b_b[i]);
      @(negedge clk);
      chk("b2b_ready", 32'(bus.ready_o), 32'd1);
      chk("b2b_result", bus.result, b2b_exp[i]);
    end
    bus.valid_i = 1'b0;
    @(negedge clk);
    chk("b2b_ready_end", 32'(bus.ready_o), 32'd0);

    // Divide and remainder
    run_op(3'd3, 32'd100, 32'd7);
    run_op(3'd4, 32'd100, 32'd7);
    run_op(3'd3, 32'hFFFF_FFFF, 32'd1);
    run_op(3'd3, 32'd5, 32'hFFFF_FFFF);
    run_op(3'd4, 32'd5, 32'hFFFF_FFFF);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Request while busy is dropped: one response only
    drive(3'd3, 32'd100, 32'd7);
    @(negedge clk);
    bus.valid_i = 1'b0;
    pulses = 0;
    first  = 0;
    got    = '0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 5) drive(3'd0, 32'd1, 32'd1);
      if (c == 6) bus.valid_i = 1'b0;
      if (bus.ready_o) begin
        pulses++;
        if (first == 0) begin
          first = c;
          got   = bus.result;
        end
      end
      @(negedge clk);
    end
    chk("drop_pulses", 32'(pulses), 32'd1);
    chk("drop_latency", 32'(first), 32'd32);
    chk("drop_result", got, 32'd14);

    // Divide by zero early out
    run_op(3'd3, 32'd55, 32'd0);
    run_op(3'd4, 32'd55, 32'd0);

    // Reset in the middle of a divide aborts it
    drive(3'd3, 32'd1000, 32'd3);
    @(negedge clk);
    bus.valid_i = 1'b0;
    repeat (9) @(negedge clk);
    rst_i = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy_o), 32'd0);
    chk("abort_ready", 32'(bus.ready_o), 32'd0);
    chk("abort_result", bus.result, 32'd0);
    chk("abort_div_zero", 32'(bus.div_zero_o), 32'd0);
    @(negedge clk);
    rst_i  = 1'b1;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.ready_o) pulses++;
    end
    chk("abort_no_ready", 32'(pulses), 32'd0);
    run_op(3'd0, 32'd2, 32'd2);

    // Random back-to-back fast ops through an expected queue
    for (int i = 0; i < 20; i++) begin
      op = fast_ops[$urandom_range(0, 5)];
      a  = $urandom;
      b  = $urandom;
      ref_model(op, a, b, er, edz, elat);
      exp_q.push_back(er);
      drive(op, a, b);
      @(negedge clk);
      chk("rnd_b2b_ready", 32'(bus.ready_o), 32'd1);
      chk("rnd_b2b_result", bus.result, exp_q.pop_front());
    end
    bus.valid_i = 1'b0;
    @(negedge clk);

    // Random single operations of every kind, including zero and small divisors
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 255));
        default: b = $urandom;
      endcase
      run_op(op, a, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
